// File: rtl/fp_accumulate.sv
`default_nettype none
// ============================================================================
// Module      : fp_accumulate
// Description : Frame-based saturating fixed-point accumulator (I.F in, IA.FA out)
// Revision    : 1.0 - initial release
// ============================================================================
module fp_accumulate #(
  parameter int I  = 2,
  parameter int F  = 14,
  parameter int IA = 6,
  parameter int FA = 14,
  parameter int LW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LW-1:0]        len,
  input  logic [I+F-1:0]       in,
  input  logic                 i_sign,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [IA+FA-1:0]     out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int W = IA + FA;
  localparam int N = I + F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_in_ready;
  logic                w_out_valid;
  logic [LW-1:0]       r_len;
  logic [LW-1:0]       r_cnt;
  logic [LW-1:0]       w_cnt_inc;
  logic [W-1:0]        r_acc;
  logic                r_ovf;
  logic                r_unf;
  logic signed [W-1:0] w_ext;
  logic signed [W-1:0] w_al;
  logic [W:0]          w_sum;
  logic                w_pos_sat;
  logic                w_neg_sat;
  logic [W-1:0]        w_sat;

  generate
    if (W > N) begin : g_ext_wide
      assign w_ext = {{(W-N){i_sign & in[N-1]}}, in};
    end else begin : g_ext_same
      assign w_ext = in[W-1:0];
    end
  endgenerate

  // Right shift is arithmetic so dropped fraction bits round toward minus infinity.
  generate
    if (FA >= F) begin : g_align_left
      assign w_al = w_ext <<< (FA - F);
    end else begin : g_align_right
      assign w_al = w_ext >>> (F - FA);
    end
  endgenerate

  assign w_sum     = {r_acc[W-1], r_acc} + {w_al[W-1], w_al};
  assign w_pos_sat = (w_sum[W:W-1] == 2'b01);
  assign w_neg_sat = (w_sum[W:W-1] == 2'b10);
  assign w_cnt_inc = r_cnt + {{(LW-1){1'b0}}, 1'b1};

  always_comb begin
    w_sat = w_sum[W-1:0];
    if (w_pos_sat) begin
      w_sat = {1'b0, {(W-1){1'b1}}};
    end else if (w_neg_sat) begin
      w_sat = {1'b1, {(W-1){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        w_in_ready = 1'b1;
        if (in_valid && (w_cnt_inc == r_len)) begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (out_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      r_len <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            r_len <= len;
            r_cnt <= '0;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            r_acc <= w_sat;
            r_ovf <= r_ovf | w_pos_sat;
            r_unf <= r_unf | w_neg_sat;
            r_cnt <= w_cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out       = r_acc;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_fp_accumulate.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_accumulate
// Description : Directed self-checking bench for fp_accumulate
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_accumulate;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic [15:0] in_s;
  logic        i_sign;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] out;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic        underflow;

  int n_checks = 0;
  int n_errors = 0;

  fp_accumulate dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in        (in_s),
    .i_sign    (i_sign),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic start_frame(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    check("in_ready_at_start", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] s, input logic sg);
    check("in_ready_accum", {31'd0, in_ready}, 32'd1);
    in_s     = s;
    i_sign   = sg;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic finish_frame(input string tag, input logic [19:0] exp_out,
                              input logic exp_ovf, input logic exp_unf, input int stall);
    for (int k = 0; k < stall; k++) begin
      start = 1'b1;
      len   = 8'd1;
      check({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_stall_out"}, {12'd0, out}, {12'd0, exp_out});
      check({tag, "_stall_flags"}, {30'd0, overflow, underflow}, {30'd0, exp_ovf, exp_unf});
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_out"}, {12'd0, out}, {12'd0, exp_out});
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
    check({tag, "_unf"}, {31'd0, underflow}, {31'd0, exp_unf});
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_idle_out"}, {12'd0, out}, {12'd0, exp_out});
    check({tag, "_idle_in_ready"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out"}, {12'd0, out}, 32'd0);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_flags"}, {30'd0, overflow, underflow}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = 8'd0; in_s = 16'd0;
    i_sign = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    // 4 x 1.0 unsigned = 4.0
    start_frame(8'd4);
    for (int k = 0; k < 4; k++) send(16'h4000, 1'b0);
    finish_frame("sum4", 20'h10000, 1'b0, 1'b0, 0);

    // -1.0 signed + 0.5 unsigned, with a bubble in between
    start_frame(8'd2);
    send(16'hC000, 1'b1);
    @(negedge clk);
    check("bubble_in_ready", {31'd0, in_ready}, 32'd1);
    send(16'h2000, 1'b0);
    finish_frame("mixed", 20'hFE000, 1'b0, 1'b0, 0);

    // 10 x 3.99994 unsigned saturates high; hold result 5 cycles with start pulsed
    start_frame(8'd10);
    for (int k = 0; k < 10; k++) send(16'hFFFF, 1'b0);
    finish_frame("ovf", 20'h7FFFF, 1'b1, 1'b0, 5);

    // sample offered in IDLE is ignored; zero-length frame clears flags
    in_s = 16'h7FFF; i_sign = 1'b0; in_valid = 1'b1;
    check("idle_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    start_frame(8'd0);
    finish_frame("len0", 20'h00000, 1'b0, 1'b0, 0);

    // 20 x -2.0 signed saturates low
    start_frame(8'd20);
    for (int k = 0; k < 20; k++) send(16'h8000, 1'b1);
    finish_frame("unf", 20'h80000, 1'b0, 1'b1, 0);

    // reset mid-frame, asserted together with start/in_valid/out_ready
    start_frame(8'd4);
    send(16'h4000, 1'b0);
    send(16'h4000, 1'b0);
    rst = 1'b1; start = 1'b1; len = 8'd3; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check_reset_state("midrst");
    start_frame(8'd1);
    send(16'h4000, 1'b0);
    finish_frame("len1", 20'h04000, 1'b0, 1'b0, 0);

    // reset while a saturated result waits in DONE
    start_frame(8'd10);
    for (int k = 0; k < 10; k++) send(16'hFFFF, 1'b0);
    check("done_ovf_pre", {31'd0, overflow}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("donerst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
